// File: rtl/keys_paddle_ctrl.sv
// keys_paddle_ctrl
//   Turns the four board keys into paddle stimulus for the racing game core.
//   Each key is synchronised and debounced. Two 8-bit paddle positions are
//   stepped once per video frame, and each one is turned back into a pulse
//   that is high for the single scanline whose number equals that position.
//
// Ports
//   clk        pixel clock, the same divided clock as the game core
//   reset      asynchronous, active-high reset
//   keys       raw keys: [0] left, [1] right, [2] up, [3] down
//   vsync      vsync from the hvsync generator
//   vpos       current scanline from the hvsync generator
//   hpaddle    horizontal paddle pulse to the core
//   vpaddle    vertical paddle pulse to the core
//   hpos_val   current horizontal paddle position
//   vpos_val   current vertical paddle position
//   frame_tick one-cycle pulse in the cycle the positions are updated
module keys_paddle_ctrl #(
  parameter logic [15:0] DEB_CYCLES = 16'd1000,
  parameter logic [7:0]  STEP       = 8'd2,
  parameter logic [7:0]  POS_MIN    = 8'd0,
  parameter logic [7:0]  POS_MAX    = 8'd255,
  parameter logic [7:0]  POS_INIT   = 8'd128,
  parameter logic        VS_ACTIVE  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] keys,
  input  logic       vsync,
  input  logic [9:0] vpos,
  output logic       hpaddle,
  output logic       vpaddle,
  output logic [7:0] hpos_val,
  output logic [7:0] vpos_val,
  output logic       frame_tick
);

  localparam logic [0:0] S_WAIT_VS = 1'b0;
  localparam logic [0:0] S_APPLY   = 1'b1;

  logic [3:0]  sync1_q, sync2_q;
  logic [3:0]  deb_q, deb_d;
  logic [15:0] cnt_q [4];
  logic [15:0] cnt_d [4];
  logic        vs_prev_q;
  logic [0:0]  state_q, state_d;
  logic [7:0]  hpos_q, hpos_d;
  logic [7:0]  vpos_q, vpos_d;
  logic        hpaddle_q, hpaddle_d;
  logic        vpaddle_q, vpaddle_d;
  logic        vs_edge;

  // Saturating step. Done in 10-bit signed so pos-STEP below zero or
  // pos+STEP above 255 is seen as out of range instead of wrapping.
  function automatic logic [7:0] step_pos(input logic [7:0] pos,
                                          input logic       dec,
                                          input logic       inc);
    logic signed [9:0] down;
    logic signed [9:0] up;
    down = $signed({2'b00, pos}) - $signed({2'b00, STEP});
    up   = $signed({2'b00, pos}) + $signed({2'b00, STEP});
    step_pos = pos;
    if (dec && !inc) begin
      step_pos = (down < $signed({2'b00, POS_MIN})) ? POS_MIN : down[7:0];
    end else if (inc && !dec) begin
      step_pos = (up > $signed({2'b00, POS_MAX})) ? POS_MAX : up[7:0];
    end
  endfunction

  // Debounce: a key state is accepted once the synced value has differed
  // from the debounced value for DEB_CYCLES consecutive samples.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path
    // leaves it unassigned and no latch is inferred.
    deb_d = deb_q;
    for (int k = 0; k < 4; k++) begin
      cnt_d[k] = cnt_q[k];
      if (sync2_q[k] != deb_q[k]) begin
        if (cnt_q[k] == DEB_CYCLES - 16'd1) begin
          deb_d[k] = ~deb_q[k];
          cnt_d[k] = '0;
        end else begin
          cnt_d[k] = cnt_q[k] + 16'd1;
        end
      end else begin
        cnt_d[k] = '0;
      end
    end
  end

  // Frame FSM: one update per vsync edge into the active level.
  assign vs_edge = (vsync == VS_ACTIVE) && (vs_prev_q != VS_ACTIVE);

  always_comb begin
    state_d = state_q;
    hpos_d  = hpos_q;
    vpos_d  = vpos_q;
    case (state_q)
      S_WAIT_VS: if (vs_edge) state_d = S_APPLY;
      S_APPLY: begin
        hpos_d  = step_pos(hpos_q, deb_q[0], deb_q[1]);
        vpos_d  = step_pos(vpos_q, deb_q[2], deb_q[3]);
        state_d = S_WAIT_VS;
      end
      default: state_d = S_WAIT_VS;
    endcase
  end

  // Scanlines 256 and up can never match an 8-bit position.
  always_comb begin
    hpaddle_d = (vpos[9:8] == 2'b00) && (vpos[7:0] == hpos_q);
    vpaddle_d = (vpos[9:8] == 2'b00) && (vpos[7:0] == vpos_q);
  end

  // NOTE: sequential state is written with non-blocking assignments so
  // every flop samples the values from before this clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      // NOTE: the counter array is small flop storage, not RAM, and a
      // half-counted glitch must not survive reset, so it is cleared too.
      for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
      // Loading the active level means a vsync already active when reset
      // drops is not mistaken for a fresh edge.
      vs_prev_q <= VS_ACTIVE;
      state_q   <= S_WAIT_VS;
      hpos_q    <= POS_INIT;
      vpos_q    <= POS_INIT;
      hpaddle_q <= 1'b0;
      vpaddle_q <= 1'b0;
    end else begin
      sync1_q   <= keys;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      for (int k = 0; k < 4; k++) cnt_q[k] <= cnt_d[k];
      vs_prev_q <= vsync;
      state_q   <= state_d;
      hpos_q    <= hpos_d;
      vpos_q    <= vpos_d;
      hpaddle_q <= hpaddle_d;
      vpaddle_q <= vpaddle_d;
    end
  end

  assign hpaddle    = hpaddle_q;
  assign vpaddle    = vpaddle_q;
  assign hpos_val   = hpos_q;
  assign vpos_val   = vpos_q;
  assign frame_tick = (state_q == S_APPLY);

endmodule

// File: tb/tb_keys_paddle_ctrl.sv
// tb_keys_paddle_ctrl
//   Directed bench for keys_paddle_ctrl with a short debounce window.
//   Instance a starts at the default position 128; instance b starts at 3
//   so the lower saturation limit can be reached on an odd step boundary.
module tb_keys_paddle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       vsync;
  logic [9:0] vpos;
  logic [3:0] keys_a, keys_b;

  logic       hpaddle_a, vpaddle_a, ft_a;
  logic [7:0] hpos_a, vpos_a;
  logic       hpaddle_b, vpaddle_b, ft_b;
  logic [7:0] hpos_b, vpos_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  keys_paddle_ctrl #(.DEB_CYCLES(16'd4), .STEP(8'd2), .POS_INIT(8'd128)) dut_a (
    .clk(clk), .reset(reset), .keys(keys_a), .vsync(vsync), .vpos(vpos),
    .hpaddle(hpaddle_a), .vpaddle(vpaddle_a), .hpos_val(hpos_a),
    .vpos_val(vpos_a), .frame_tick(ft_a)
  );

  keys_paddle_ctrl #(.DEB_CYCLES(16'd4), .STEP(8'd2), .POS_INIT(8'd3)) dut_b (
    .clk(clk), .reset(reset), .keys(keys_b), .vsync(vsync), .vpos(vpos),
    .hpaddle(hpaddle_b), .vpaddle(vpaddle_b), .hpos_val(hpos_b),
    .vpos_val(vpos_b), .frame_tick(ft_b)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // All stimulus is driven and all outputs sampled on the falling edge.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One video frame: vsync inactive, then active for a few lines, then
  // inactive. Exactly one frame_tick must appear on instance a.
  task automatic frame();
    int ticks;
    ticks = 0;
    vsync = 1'b1;
    cyc(2);
    vsync = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      if (ft_a) ticks++;
    end
    vsync = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc(1);
      if (ft_a) ticks++;
    end
    check("tick_per_frame", ticks, 1);
  endtask

  initial begin
    reset  = 1'b1;
    vsync  = 1'b0;
    vpos   = 10'd128;
    keys_a = 4'b0000;
    keys_b = 4'b0000;
    cyc(2);

    // Reset state
    check("rst_hpos", hpos_a, 128);
    check("rst_vpos", vpos_a, 128);
    check("rst_hpaddle", hpaddle_a, 0);
    check("rst_vpaddle", vpaddle_a, 0);
    check("rst_tick", ft_a, 0);
    check("rst_b_hpos", hpos_b, 3);

    // vsync already active at release: no tick
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check("no_tick_after_rst", ft_a, 0);
    end
    vpos = 10'd600;

    // Short key glitches are rejected
    keys_a = 4'b0010;
    cyc(3);
    keys_a = 4'b0000;
    cyc(8);
    frame();
    check("glitch3_hpos", hpos_a, 128);
    keys_a = 4'b0010;
    cyc(4);
    keys_a = 4'b0000;
    cyc(8);
    frame();
    check("glitch4_hpos", hpos_a, 128);

    // Hold right 10 frames on a; hold left on b (3 -> 1 -> 0 -> 0)
    keys_a = 4'b0010;
    keys_b = 4'b0001;
    cyc(8);
    for (int f = 1; f <= 10; f++) begin
      frame();
      if (f == 1) check("b_left_f1", hpos_b, 1);
      if (f == 2) check("b_left_f2", hpos_b, 0);
    end
    check("right_10_frames", hpos_a, 148);
    check("b_left_floor", hpos_b, 0);
    check("b_vpos_idle", vpos_b, 3);
    keys_b = 4'b0000;

    // Keep right held up to the top limit: 254 -> 255 -> 255
    for (int f = 0; f < 53; f++) frame();
    check("right_254", hpos_a, 254);
    frame();
    check("right_255", hpos_a, 255);
    frame();
    check("right_sat", hpos_a, 255);
    keys_a = 4'b0000;
    cyc(8);

    // Opposing keys cancel
    keys_a = 4'b0011;
    cyc(8);
    for (int f = 0; f < 5; f++) frame();
    check("lr_both_hpos", hpos_a, 255);
    keys_a = 4'b1100;
    cyc(8);
    for (int f = 0; f < 5; f++) frame();
    check("ud_both_vpos", vpos_a, 128);
    check("ud_both_hpos", hpos_a, 255);
    keys_a = 4'b0000;
    cyc(8);

    // Up 44 frames: vpos_val 128 -> 40
    keys_a = 4'b0100;
    cyc(8);
    for (int f = 0; f < 44; f++) frame();
    check("up_to_40", vpos_a, 40);
    keys_a = 4'b0000;
    cyc(8);

    // Scanline sweep: pulses one clock after the matching vpos
    for (int i = 0; i < 525; i++) begin
      vpos = 10'(i);
      cyc(1);
      check("vpaddle_sweep", vpaddle_a, (i == 40) ? 1 : 0);
      check("hpaddle_sweep", hpaddle_a, (i == 255) ? 1 : 0);
    end
    vpos = 10'd600;

    // Reset during APPLY with down held
    keys_a = 4'b1000;
    cyc(8);
    vsync = 1'b1;
    cyc(2);
    vsync = 1'b0;
    cyc(1);
    check("apply_reached", ft_a, 1);
    reset = 1'b1;
    #1;
    check("midrst_vpos", vpos_a, 128);
    check("midrst_hpos", hpos_a, 128);
    check("midrst_tick", ft_a, 0);
    cyc(2);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      check("no_tick_post_rst", ft_a, 0);
    end
    cyc(8);
    frame();
    check("down_after_rst", vpos_a, 130);
    check("hpos_after_rst", hpos_a, 128);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
